// File: rtl/fp16_unpack_norm.sv
// fp16_unpack_norm
// Operand front end for the fp16 FMA datapath. Accepts one packed binary16
// operand per handshake, classifies it and emits sign, unbiased exponent and
// an 11-bit significand with an explicit leading one. Subnormals are
// normalized with one left shift per cycle, so the consumer only ever sees
// normalized significands.
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   in_valid/ready  input handshake, in_x = {sign, exp[4:0], frac[9:0]}
//   out_valid/ready output handshake
//   out_sign        operand sign (unchanged for every class)
//   out_exp         unbiased exponent, 7-bit two's complement
//   out_sig         {lead bit, fraction}
//   out_zero/subnorm/inf/nan/snan  class flags (out_snan implies out_nan)
//
// state | meaning
// IDLE  | empty, ready for an operand
// NORM  | subnormal being shifted left until the lead bit is set
// DONE  | result presented, held until the consumer takes it
module fp16_unpack_norm (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_x,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sign,
    output logic [6:0]  out_exp,
    output logic [10:0] out_sig,
    output logic        out_zero,
    output logic        out_subnorm,
    output logic        out_inf,
    output logic        out_nan,
    output logic        out_snan
);

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t state;

    logic        accept;
    logic [4:0]  x_exp;
    logic [9:0]  x_frac;
    logic [6:0]  dec_exp;
    logic [10:0] dec_sig;
    logic        dec_zero;
    logic        dec_subnorm;
    logic        dec_inf;
    logic        dec_nan;
    logic        dec_snan;

    // DONE accepts a new operand in the same cycle its result is taken.
    assign in_ready  = !reset && ((state == IDLE) || ((state == DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);

    assign x_exp  = in_x[14:10];
    assign x_frac = in_x[9:0];

    always_comb begin
        dec_exp     = '0;
        dec_sig     = '0;
        dec_zero    = 1'b0;
        dec_subnorm = 1'b0;
        dec_inf     = 1'b0;
        dec_nan     = 1'b0;
        dec_snan    = 1'b0;
        if (x_exp == 5'd0) begin
            if (x_frac == 10'd0) begin
                dec_zero = 1'b1;
            end else begin
                // Subnormal starts at the minimum exponent; NORM walks it down.
                dec_sig     = {1'b0, x_frac};
                dec_exp     = 7'h72;
                dec_subnorm = 1'b1;
            end
        end else if (x_exp == 5'd31) begin
            // {1,frac} gives 0x400 for infinity and keeps the NaN payload.
            dec_exp  = 7'h10;
            dec_sig  = {1'b1, x_frac};
            dec_inf  = (x_frac == 10'd0);
            dec_nan  = (x_frac != 10'd0);
            dec_snan = (x_frac != 10'd0) && !x_frac[9];
        end else begin
            dec_exp = {2'b00, x_exp} - 7'd15;
            dec_sig = {1'b1, x_frac};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            out_sign    <= 1'b0;
            out_exp     <= '0;
            out_sig     <= '0;
            out_zero    <= 1'b0;
            out_subnorm <= 1'b0;
            out_inf     <= 1'b0;
            out_nan     <= 1'b0;
            out_snan    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        out_sign    <= in_x[15];
                        out_exp     <= dec_exp;
                        out_sig     <= dec_sig;
                        out_zero    <= dec_zero;
                        out_subnorm <= dec_subnorm;
                        out_inf     <= dec_inf;
                        out_nan     <= dec_nan;
                        out_snan    <= dec_snan;
                        state       <= dec_subnorm ? NORM : DONE;
                    end else if ((state == DONE) && out_ready) begin
                        state <= IDLE;
                    end
                end
                NORM: begin
                    out_sig <= out_sig << 1;
                    out_exp <= out_exp - 7'd1;
                    // bit 9 becomes the lead bit after this shift
                    if (out_sig[9]) begin
                        state <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/fp16_unpack_norm.md
# fp16_unpack_norm

Operand front end for the fp16 FMA datapath, mirroring the back-end rounding/packing stage. It accepts one packed IEEE-754 binary16 operand per handshake, classifies it, and emits an unpacked form: sign, unbiased exponent and an 11-bit significand with explicit leading one. Subnormal operands are normalized iteratively, one left shift per cycle, so downstream multiply/add logic sees only normalized significands. Valid/ready handshakes are used on both sides.

## Interface
- No parameters (format fixed to binary16).
- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operand present on in_x.
- in_ready  output  1  block can accept an operand this cycle.
- in_x  input  16  packed fp16 {sign, exp[4:0], frac[9:0]}.
- out_valid  output  1  unpacked result present.
- out_ready  input  1  consumer takes result this cycle.
- out_sign  output  1  operand sign.
- out_exp  output  7  unbiased exponent, two's complement.
- out_sig  output  11  significand {lead bit, fraction}.
- out_zero, out_subnorm, out_inf, out_nan, out_snan  output  1 each  class flags; exactly one of zero/subnorm/inf/nan, or none for normals; out_snan implies out_nan.

## Operation
- Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
- FSM states: IDLE, NORM, DONE.
- IDLE: in_ready=1. On accept, decode in_x and register fields:
  - exp 1..30 (normal): out_exp = exp-15, out_sig = {1,frac}; -> DONE.
  - exp 0, frac 0 (zero): out_exp = 0, out_sig = 0, out_zero=1; -> DONE.
  - exp 31, frac 0 (inf): out_exp = +16, out_sig = 0x400, out_inf=1; -> DONE.
  - exp 31, frac≠0 (NaN): out_exp = +16, out_sig = {1,frac}, out_nan=1, out_snan = ~frac[9]; -> DONE.
  - exp 0, frac≠0 (subnormal): load out_sig = {0,frac}, out_exp = -14, out_subnorm=1; -> NORM.
- NORM: each cycle out_sig <<= 1, out_exp -= 1; when post-shift out_sig[10]=1 -> DONE. Shift count = leading zeros of frac + 1 (1..10). Final out_exp range -15..-24 (7'h71..7'h68); out_sig[10]=1.
- DONE: out_valid=1; all outputs held stable until transfer. On transfer: if in_valid also high, accept the new operand in the same cycle (in_ready = out_ready in DONE) and decode as in IDLE; else -> IDLE.
- Sign passes through unmodified for every class (−0 gives out_sign=1, out_zero=1).
- out_valid is 0 in IDLE and NORM; in_ready is 0 in NORM.
- Exponent arithmetic is 7-bit two's complement; no overflow is possible within the range -24..+16.

## Timing
- Reset (clk edge with reset=1): state IDLE, out_valid=0, all data/flag outputs 0. in_ready=0 while reset is high, 1 on the first cycle after it is released.
- Reset while in NORM or DONE discards the in-flight operand; no output is produced for it.
- Latency, measured from the accept edge: normal, zero, inf and NaN give out_valid in the next cycle (1 cycle). Subnormal gives 1 + shift count cycles; 0x0001 takes 11 cycles.
- Throughput: one non-subnormal operand per cycle when out_ready stays high (DONE→DONE). After an idle gap, one result per 2 cycles.
- in_ready is a combinational function of state and out_ready only; it never depends on in_valid.
- out_ready low in DONE: outputs frozen and in_ready=0 for as long as it stays low.

## Test plan
- 0x3C00 accepted, out_ready=1 → next cycle out_valid=1, sign 0, exp 7'h00, sig 0x400, no flags.
- 0x0001 → out_valid exactly 11 cycles after accept, exp 7'h68 (−24), sig 0x400, out_subnorm=1; in_ready=0 throughout NORM.
- 0x8200 → 1 shift, out_valid 2 cycles after accept, sign 1, exp 7'h71 (−15), sig 0x400, subnorm=1.
- 0x7C00 / 0x7E00 / 0x7C01 / 0x8000 → inf (exp 7'h10, sig 0x400); qNaN (nan=1, snan=0, sig 0x600); sNaN (nan=1, snan=1, sig 0x401); zero (sign 1, exp 0, sig 0).
- 0x4000 result held with out_ready=0 for 5 cycles → outputs stable, in_ready=0. Then out_ready=1 with 0xC000 and 0x4200 queued → transfers in consecutive cycles: exp 7'h01 with sig 0x400 sign 1, then exp 7'h01 with sig 0x600.
- reset asserted on the 3rd NORM cycle of 0x0001 → next cycle out_valid=0 and all outputs 0. After release, 0x3C00 completes in 1 cycle.
